// File: rtl/pipe_pkg.sv
// Shared definitions for the core's pipeline stage registers.
//   pipe_state_t : occupancy state of one pipe_stage_reg instance
//   *_W          : payload width of each inter-stage register
//   NOP_INSTR    : instruction encoding used to build bubble payloads
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } pipe_state_t;

   localparam int IF_ID_W  = 64;   // {next_pc, instruction}
   localparam int ID_EX_W  = 128;
   localparam int EX_MEM_W = 104;
   localparam int MEM_WB_W = 72;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   localparam logic [IF_ID_W-1:0] IF_ID_BUBBLE = {32'h0000_0000, NOP_INSTR};

endpackage

// File: rtl/pipe_slot.sv
// One payload slot of a pipeline stage: WIDTH-bit register plus valid bit.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (slot -> BUBBLE, invalid)
//   clear        : load BUBBLE and mark invalid (wins over load)
//   load         : capture d and mark valid
//   d            : payload in
//   q, valid     : held payload and its valid bit
module pipe_slot #(
   parameter int               WIDTH  = 64,
   parameter logic [WIDTH-1:0] BUBBLE = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             valid
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q     <= BUBBLE;
         valid <= 1'b0;
      end else if (clear) begin
         q     <= BUBBLE;
         valid <= 1'b0;
      end else if (load) begin
         q     <= d;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable valid/ready pipeline stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Build option: define PIPE_REG_SKID_EN for a 2-entry skid buffer with a
// registered in_ready; otherwise single slot with combinational in_ready.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   flush                 : synchronous flush, drops held and incoming entries
//   in_valid/in_ready/in_data    : upstream handshake
//   out_valid/out_ready/out_data : downstream handshake (out_ready = 0 stalls)
//   occupancy             : held entries, 0..2
//
// state | meaning
// EMPTY | nothing held, out_data = BUBBLE
// FULL  | main slot valid
// SKID  | main and skid slots valid, in_ready = 0 (skid build only)
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int               WIDTH  = 64,
   parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   pipe_state_t      state, state_nxt;
   logic             accept, consume;
   logic             main_load, main_clear, main_v;
   logic [WIDTH-1:0] main_d;

`ifdef PIPE_REG_SKID_EN
   logic             skid_load, skid_clear, skid_v;
   logic [WIDTH-1:0] skid_q;
   logic             in_ready_q;
`endif

   assign accept  = in_valid & in_ready;
   assign consume = main_v & out_ready;

   always_comb begin
      state_nxt  = state;
      main_load  = 1'b0;
      main_clear = 1'b0;
      main_d     = in_data;
`ifdef PIPE_REG_SKID_EN
      skid_load  = 1'b0;
      skid_clear = 1'b0;
`endif
      if (flush) begin
         state_nxt  = EMPTY;
         main_clear = 1'b1;
`ifdef PIPE_REG_SKID_EN
         skid_clear = 1'b1;
`endif
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  main_load = 1'b1;
                  state_nxt = FULL;
               end
            end
            FULL: begin
               if (accept && consume) begin
                  main_load = 1'b1;
               end else if (consume) begin
                  main_clear = 1'b1;
                  state_nxt  = EMPTY;
               end
`ifdef PIPE_REG_SKID_EN
               else if (accept) begin
                  skid_load = 1'b1;
                  state_nxt = SKID;
               end
`endif
            end
`ifdef PIPE_REG_SKID_EN
            SKID: begin
               // in_ready is low here, so only the skid-to-main move can occur
               if (consume) begin
                  main_load  = 1'b1;
                  main_d     = skid_q;
                  skid_clear = 1'b1;
                  state_nxt  = FULL;
               end
            end
`endif
            default: begin
               state_nxt  = EMPTY;
               main_clear = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   pipe_slot #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_main_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (main_clear),
      .load    (main_load),
      .d       (main_d),
      .q       (out_data),
      .valid   (main_v)
   );

   assign out_valid = main_v;

`ifdef PIPE_REG_SKID_EN
   pipe_slot #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_skid_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (skid_clear),
      .load    (skid_load),
      .d       (in_data),
      .q       (skid_q),
      .valid   (skid_v)
   );

   // Registered ready breaks the out_ready -> in_ready combinational path;
   // the skid slot absorbs the one entry accepted while this lags a stall.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_ready_q <= 1'b1;
      end else begin
         in_ready_q <= (state_nxt != SKID);
      end
   end

   assign in_ready  = in_ready_q;
   assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
`else
   assign in_ready  = !main_v | out_ready;
   assign occupancy = {1'b0, main_v};
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

   localparam int W = 64;

   logic         clk;
   logic         reset_n;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic [1:0]   occupancy;

   int checks = 0;
   int errors = 0;

   pipe_stage_reg #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic [63:0] d, input logic ordy, input logic fl);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
   endtask

   typedef struct {
      logic         iv;
      logic [63:0]  d;
      logic         ordy;
      logic         fl;
      logic         ev;
      logic [63:0]  ed;
      logic [1:0]   eocc;
   } vec_t;

   vec_t vecs[10];

   logic [63:0] sb[$];
   logic [63:0] exp_front;
   logic        pre_ir;
   int          sent, cycles;

   initial begin
      // {in_valid, in_data, out_ready, flush} -> {out_valid, out_data, occupancy} after the edge
      vecs[0] = '{1'b1, 64'h1, 1'b1, 1'b0, 1'b1, 64'h1, 2'd1};
      vecs[1] = '{1'b1, 64'h2, 1'b1, 1'b0, 1'b1, 64'h2, 2'd1};
      vecs[2] = '{1'b1, 64'h3, 1'b1, 1'b0, 1'b1, 64'h3, 2'd1};
      vecs[3] = '{1'b0, 64'h4, 1'b1, 1'b0, 1'b0, 64'h0, 2'd0};
      vecs[4] = '{1'b1, 64'h5, 1'b0, 1'b0, 1'b1, 64'h5, 2'd1};
      vecs[5] = '{1'b0, 64'h6, 1'b0, 1'b0, 1'b1, 64'h5, 2'd1};
      vecs[6] = '{1'b0, 64'h6, 1'b1, 1'b0, 1'b0, 64'h0, 2'd0};
      vecs[7] = '{1'b1, 64'h7, 1'b0, 1'b0, 1'b1, 64'h7, 2'd1};
      vecs[8] = '{1'b0, 64'h8, 1'b0, 1'b1, 1'b0, 64'h0, 2'd0};
      vecs[9] = '{1'b1, 64'h9, 1'b1, 1'b1, 1'b0, 64'h0, 2'd0};

      reset_n = 1'b0;
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_in_ready", in_ready, 1);
      reset_n = 1'b1;

      // Reset asserted mid-cycle while FULL
      drive(1'b1, 64'hDEAD_BEEF_0000_0004, 1'b0, 1'b0);
      step();
      chk("full_before_rst", out_data, 64'hDEAD_BEEF_0000_0004);
      chk("full_valid_before_rst", out_valid, 1);
      in_valid = 1'b0;
      #3;
      reset_n = 1'b0;
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_out_data", out_data, 0);
      chk("async_rst_occupancy", occupancy, 0);
      chk("async_rst_in_ready", in_ready, 1);
      reset_n = 1'b1;

      // Table: streaming, drain, stall hold, flush priority
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
         step();
         chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].ev);
         chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].ed);
         chk($sformatf("vec%0d_occupancy", i), occupancy, vecs[i].eocc);
      end

      // Stall hold with a second payload offered during the stall
      drive(1'b1, 64'hA, 1'b1, 1'b0);
      step();
      chk("stall_load_a", out_data, 64'hA);
      drive(1'b1, 64'hB, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("stall%0d_out_data", c), out_data, 64'hA);
         chk($sformatf("stall%0d_out_valid", c), out_valid, 1);
         chk($sformatf("stall%0d_in_ready", c), in_ready, 0);
`ifdef PIPE_REG_SKID_EN
         chk($sformatf("stall%0d_occupancy", c), occupancy, 2);
         in_valid = 1'b0;
`else
         chk($sformatf("stall%0d_occupancy", c), occupancy, 1);
`endif
      end
      out_ready = 1'b1;
      #1;
      chk("release_a_on_output", out_data, 64'hA);
`ifdef PIPE_REG_SKID_EN
      chk("release_in_ready_registered", in_ready, 0);
`else
      chk("release_in_ready_comb", in_ready, 1);
`endif
      step();
      chk("release_b_out_data", out_data, 64'hB);
      chk("release_b_out_valid", out_valid, 1);
      chk("release_b_occupancy", occupancy, 1);
      in_valid = 1'b0;
      step();
      chk("release_drained", out_valid, 0);

      // Flush with an incoming payload present
      drive(1'b1, 64'h11, 1'b0, 1'b0);
      step();
      drive(1'b1, 64'h12, 1'b0, 1'b0);
      step();
`ifdef PIPE_REG_SKID_EN
      chk("pre_flush_occupancy", occupancy, 2);
`else
      chk("pre_flush_occupancy", occupancy, 1);
`endif
      drive(1'b1, 64'hC, 1'b1, 1'b1);
      step();
      chk("flush_out_valid", out_valid, 0);
      chk("flush_occupancy", occupancy, 0);
      chk("flush_out_data", out_data, 0);
      chk("flush_in_ready", in_ready, 1);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("post_flush%0d_out_valid", c), out_valid, 0);
      end

      // Randomised back-pressure against an in-order queue model
      sent   = 0;
      cycles = 0;
      while ((sent < 1000 || sb.size() != 0) && cycles < 20000) begin
         cycles++;
         pre_ir    = in_ready;
         in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
         in_data   = {$urandom, $urandom};
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
`ifdef PIPE_REG_SKID_EN
         chk("rand_in_ready_indep", in_ready, pre_ir);
         chk("rand_in_ready_occ", in_ready, occupancy != 2'd2);
`else
         chk("rand_in_ready_comb", in_ready, !out_valid | out_ready);
`endif
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rand_spurious actual=%h required=no_output", out_data);
            end else begin
               exp_front = sb.pop_front();
               chk("rand_data", out_data, exp_front);
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back(in_data);
            sent++;
         end
         step();
         chk("rand_occupancy", occupancy, sb.size());
         chk("rand_out_valid", out_valid, sb.size() != 0);
      end
      checks++;
      if (sent < 1000 || sb.size() != 0) begin
         errors++;
         $display("FAIL rand_complete actual=sent%0d_pending%0d required=sent1000_pending0", sent, sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
